// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath widths, ALU op codes and branch funct3 codes
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_NOR = 4'b1100,
    ALU_SLL = 4'b1111
  } alu_op_e;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != {PERF_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_register.sv
// rtl/ex_mem_register.sv - EX/MEM pipeline register with branch resolve, stall, flush and event counters
module ex_mem_register #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [REG_AW-1:0] rd,
  input  logic [2:0]        funct3,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [XLEN-1:0]   branch_target,
  output logic              m_valid,
  output logic [XLEN-1:0]   m_alu_result,
  output logic              m_zero,
  output logic [XLEN-1:0]   m_write_data,
  output logic [REG_AW-1:0] m_rd,
  output logic              m_mem_read,
  output logic              m_mem_write,
  output logic              m_reg_write,
  output logic              m_mem_to_reg,
  output logic              m_branch_taken,
  output logic [XLEN-1:0]   m_branch_target,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count
);

  import riscv_pkg::*;

  logic taken;

  // Only BEQ/BNE resolve here; every other funct3 falls through as not taken.
  always_comb begin
    taken = branch & ex_valid &
            (((funct3 == F3_BEQ) & alu_zero) | ((funct3 == F3_BNE) & ~alu_zero));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid         <= 1'b0;
      m_alu_result    <= '0;
      m_zero          <= 1'b0;
      m_write_data    <= '0;
      m_rd            <= '0;
      m_mem_read      <= 1'b0;
      m_mem_write     <= 1'b0;
      m_reg_write     <= 1'b0;
      m_mem_to_reg    <= 1'b0;
      m_branch_taken  <= 1'b0;
      m_branch_target <= '0;
    end else if (flush || !stall) begin
      // A flush still captures the data fields; only valid and the strobes are forced low.
      m_valid         <= ex_valid & ~flush;
      m_alu_result    <= alu_result;
      m_zero          <= alu_zero;
      m_write_data    <= rs2_data;
      m_rd            <= rd;
      m_mem_read      <= mem_read & ex_valid & ~flush;
      m_mem_write     <= mem_write & ex_valid & ~flush;
      m_reg_write     <= reg_write & ex_valid & (rd != '0) & ~flush;
      m_mem_to_reg    <= mem_to_reg;
      m_branch_taken  <= taken & ~flush;
      m_branch_target <= branch_target;
    end
  end

  sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk    (clk),
    .resetn (reset),
    .inc    (stall),
    .count  (stall_count)
  );

  sat_counter #(.PERF_W(PERF_W)) u_flush_cnt (
    .clk    (clk),
    .resetn (reset),
    .inc    (flush),
    .count  (flush_count)
  );

endmodule

// File: tb/tb_ex_mem_register.sv
// tb/tb_ex_mem_register.sv - scoreboard bench for ex_mem_register with a small-width counter instance
module tb_ex_mem_register;

  localparam int PW   = 4;
  localparam int CMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset, stall, flush, ex_valid;
  logic [63:0]   alu_result, rs2_data, branch_target;
  logic          alu_zero;
  logic [4:0]    rd;
  logic [2:0]    funct3;
  logic          branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic          m_valid, m_zero, m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg, m_branch_taken;
  logic [63:0]   m_alu_result, m_write_data, m_branch_target;
  logic [4:0]    m_rd;
  logic [PW-1:0] stall_count, flush_count;

  ex_mem_register #(.XLEN(64), .REG_AW(5), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_result(alu_result), .alu_zero(alu_zero), .rs2_data(rs2_data), .rd(rd),
    .funct3(funct3), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch_target(branch_target),
    .m_valid(m_valid), .m_alu_result(m_alu_result), .m_zero(m_zero),
    .m_write_data(m_write_data), .m_rd(m_rd), .m_mem_read(m_mem_read),
    .m_mem_write(m_mem_write), .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
    .m_branch_taken(m_branch_taken), .m_branch_target(m_branch_target),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        resetn, stall, flush, ex_valid;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic [63:0] rs2_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        branch, mem_read, mem_write, reg_write, mem_to_reg;
    logic [63:0] branch_target;
  } stim_t;

  typedef struct {
    logic        known;
    logic        valid, zero, mem_read, mem_write, reg_write, mem_to_reg, taken;
    logic [63:0] result, wdata, target;
    logic [4:0]  rd;
    int unsigned sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t mdl;
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.resetn = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.resetn        = 1'b1;
    s.stall         = ($urandom_range(0, 3) == 0);
    s.flush         = ($urandom_range(0, 5) == 0);
    s.ex_valid      = ($urandom_range(0, 3) != 0);
    s.alu_result    = {$urandom, $urandom};
    s.alu_zero      = $urandom_range(0, 1) == 1;
    s.rs2_data      = {$urandom, $urandom};
    s.rd            = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    s.funct3        = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
    s.branch        = $urandom_range(0, 1) == 1;
    s.mem_read      = $urandom_range(0, 1) == 1;
    s.mem_write     = $urandom_range(0, 1) == 1;
    s.reg_write     = $urandom_range(0, 1) == 1;
    s.mem_to_reg    = $urandom_range(0, 1) == 1;
    s.branch_target = {$urandom, $urandom};
    return s;
  endfunction

  function automatic int unsigned bump(input int unsigned c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // Drive one cycle of stimulus and record what the MEM stage must hold after the next edge.
  task automatic apply(input stim_t s);
    logic eq_hit, ne_hit;
    @(negedge clk);
    reset = s.resetn; stall = s.stall; flush = s.flush; ex_valid = s.ex_valid;
    alu_result = s.alu_result; alu_zero = s.alu_zero; rs2_data = s.rs2_data; rd = s.rd;
    funct3 = s.funct3; branch = s.branch; mem_read = s.mem_read; mem_write = s.mem_write;
    reg_write = s.reg_write; mem_to_reg = s.mem_to_reg; branch_target = s.branch_target;
    if (!s.resetn) begin
      mdl = '{default: '0};
      mdl.known = 1'b1;
    end else begin
      if (s.stall) mdl.sc = bump(mdl.sc);
      if (s.flush) mdl.fc = bump(mdl.fc);
      if (s.flush) begin
        mdl.known = 1'b0;
        mdl.valid = 0; mdl.mem_read = 0; mdl.mem_write = 0; mdl.reg_write = 0; mdl.taken = 0;
      end else if (!s.stall) begin
        eq_hit = (s.funct3 == 3'd0) && s.alu_zero;
        ne_hit = (s.funct3 == 3'd1) && !s.alu_zero;
        mdl.known      = 1'b1;
        mdl.valid      = s.ex_valid;
        mdl.result     = s.alu_result;
        mdl.zero       = s.alu_zero;
        mdl.wdata      = s.rs2_data;
        mdl.rd         = s.rd;
        mdl.target     = s.branch_target;
        mdl.mem_to_reg = s.mem_to_reg;
        mdl.mem_read   = s.ex_valid && s.mem_read;
        mdl.mem_write  = s.ex_valid && s.mem_write;
        mdl.reg_write  = s.ex_valid && s.reg_write && (s.rd != 0);
        mdl.taken      = s.ex_valid && s.branch && (eq_hit || ne_hit);
      end
    end
    q.push_back(mdl);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("m_valid",        64'(m_valid),        64'(e.valid));
        check("m_mem_read",     64'(m_mem_read),     64'(e.mem_read));
        check("m_mem_write",    64'(m_mem_write),    64'(e.mem_write));
        check("m_reg_write",    64'(m_reg_write),    64'(e.reg_write));
        check("m_branch_taken", 64'(m_branch_taken), 64'(e.taken));
        check("stall_count",    64'(stall_count),    64'(e.sc));
        check("flush_count",    64'(flush_count),    64'(e.fc));
        if (e.known) begin
          check("m_alu_result",    m_alu_result,        e.result);
          check("m_write_data",    m_write_data,        e.wdata);
          check("m_rd",            64'(m_rd),           64'(e.rd));
          check("m_zero",          64'(m_zero),         64'(e.zero));
          check("m_mem_to_reg",    64'(m_mem_to_reg),   64'(e.mem_to_reg));
          check("m_branch_target", m_branch_target,     e.target);
        end
      end
    end
  end

  initial begin : driver
    stim_t s;
    mdl = '{default: '0};

    s = idle(); s.resetn = 0; s.stall = 1; s.flush = 1;
    apply(s); apply(s);

    s = idle(); s.ex_valid = 1; s.alu_result = 64'h10; s.rd = 5; s.reg_write = 1;
    apply(s);
    s.rd = 0;
    apply(s);

    s = idle(); s.ex_valid = 1; s.branch = 1; s.funct3 = 3'b000; s.alu_zero = 1;
    apply(s);
    s.funct3 = 3'b001; apply(s);
    s.alu_zero = 0;    apply(s);
    s.funct3 = 3'b100; s.alu_zero = 1; apply(s);
    s.funct3 = 3'b000; s.ex_valid = 0; apply(s);

    s = idle(); s.resetn = 0; apply(s);
    s = idle(); s.ex_valid = 1; s.alu_result = 64'hA; s.reg_write = 1; s.rd = 3;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.stall = 1; s.flush = 0;
      apply(s);
    end

    s = idle(); s.ex_valid = 1; s.mem_write = 1; s.stall = 1; s.flush = 1;
    apply(s);

    for (int i = 0; i < CMAX + 3; i++) begin
      s = rnd(); s.stall = 1; s.flush = 0;
      apply(s);
    end
    s = rnd(); s.stall = 1; s.resetn = 0; apply(s);
    for (int i = 0; i < 2; i++) begin
      s = rnd(); s.stall = 1;
      apply(s);
    end

    for (int i = 0; i < 400; i++) begin
      s = rnd();
      if ($urandom_range(0, 63) == 0) s.resetn = 0;
      apply(s);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
